// File: rtl/led_blinker_pkg.sv
// ---------------------------------------------------------------------------
// led_blinker_pkg
// Shared definitions for the multi-channel LED blinker:
//   mode_e      channel operating modes (OFF, ON, BLINK, ONESHOT)
//   clog2Min1   ceiling log2 that never returns less than 1, used to size
//               channel-index buses so a single-channel build still has a
//               one-bit index
// ---------------------------------------------------------------------------
package led_blinker_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_ONESHOT = 2'd3
   } mode_e;

   // Ceiling log2 clamped to a minimum of 1 bit
   function automatic int clog2Min1(input int n);
      int bits;
      bits = 0;
      while ((1 << bits) < n) begin
         bits++;
      end
      return (bits < 1) ? 1 : bits;
   endfunction

endpackage

// File: rtl/led_blinker_multi_if.sv
// ---------------------------------------------------------------------------
// led_blinker_multi_if
// Configuration write port of the multi-channel LED blinker.
//   wr_en      single-cycle write strobe
//   wr_ch      channel index being written
//   wr_mode    channel mode (see led_blinker_pkg::mode_e encoding)
//   wr_period  blink period in prescaler ticks
//   wr_on      on-time in prescaler ticks
// master: the control side that issues writes
// slave : the blinker that accepts them (no backpressure)
// ---------------------------------------------------------------------------
interface led_blinker_multi_if #(
   parameter int CH_W  = 2,
   parameter int CNT_W = 16
);

   logic             wr_en;
   logic [CH_W-1:0]  wr_ch;
   logic [1:0]       wr_mode;
   logic [CNT_W-1:0] wr_period;
   logic [CNT_W-1:0] wr_on;

   modport master (
      output wr_en,
      output wr_ch,
      output wr_mode,
      output wr_period,
      output wr_on
   );

   modport slave (
      input wr_en,
      input wr_ch,
      input wr_mode,
      input wr_period,
      input wr_on
   );

endinterface

// File: rtl/led_blinker_multi_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides the system clock down to a periodic one-cycle tick pulse.
//   i_clk   system clock
//   i_rst   asynchronous, active-high reset
//   o_tick  registered pulse, high for one cycle every CLK_HZ/TICK_HZ clocks
// CLK_HZ/TICK_HZ must be an integer of at least 2.
// ---------------------------------------------------------------------------
module tick_prescaler #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 1_000
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_tick
);

   localparam int DIV     = CLK_HZ / TICK_HZ;
   localparam int PRE_MAX = DIV - 1;
   localparam int CW      = $clog2(DIV);

   logic [CW-1:0] count_q, count_d;
   logic          tick_q,  tick_d;

   // Count 0..PRE_MAX and wrap; the tick is raised on the cycle after the
   // count sits at PRE_MAX, so the first tick after reset comes DIV clocks
   // after release.
   always_comb begin
      count_d = count_q + 1'b1;
      tick_d  = 1'b0;
      if (count_q == CW'(PRE_MAX)) begin
         count_d = '0;
         tick_d  = 1'b1;
      end
   end

   // Prescaler state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   assign o_tick = tick_q;

endmodule

// File: rtl/led_blinker_multi.sv
// ---------------------------------------------------------------------------
// led_blinker_multi
// N_CH independently programmable LED channels driven from a shared tick.
//   i_clk     system clock
//   i_rst     asynchronous, active-high reset
//   i_enable  global output enable; gates o_led only, timing keeps running
//   cfg       configuration write port (slave side)
//   o_led     registered LED drive, bit k = channel k
//   o_tick    one-cycle prescaler tick pulse
// Each channel holds mode, period, on-time and a phase counter. BLINK
// cycles the phase over max(period,1) ticks and lights while phase < on.
// ONESHOT lights for exactly 'on' ticks and then drops back to OFF.
// ---------------------------------------------------------------------------
module led_blinker_multi
   import led_blinker_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 1_000,
   parameter int CNT_W   = 16,
   parameter int CH_W    = clog2Min1(N_CH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_enable,
   led_blinker_multi_if.slave cfg,
   output logic [N_CH-1:0]   o_led,
   output logic              o_tick
);

   logic            tick;
   logic [N_CH-1:0] chanOn;
   logic [N_CH-1:0] led_q;

   tick_prescaler #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) u_prescaler (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .o_tick (tick)
   );

   for (genvar k = 0; k < N_CH; k++) begin : g_chan
      mode_e            mode_q,   mode_d;
      logic [CNT_W-1:0] period_q, period_d;
      logic [CNT_W-1:0] on_q,     on_d;
      logic [CNT_W-1:0] phase_q,  phase_d;
      logic [CNT_W-1:0] effPeriod;
      logic [CNT_W-1:0] phaseInc;
      logic             wrHit;
      logic             chanOnK;

      // Only an index that names this channel hits; indices at or above
      // N_CH match no generate instance and are silently dropped.
      assign wrHit     = cfg.wr_en && (int'(cfg.wr_ch) == k);
      assign effPeriod = (period_q == '0) ? CNT_W'(1) : period_q;
      assign phaseInc  = phase_q + 1'b1;

      // Next-state logic. A write always beats a coincident tick and
      // restarts the phase. BLINK wraps on the effective period; ONESHOT
      // ignores the period and retires itself once 'on' ticks have elapsed.
      always_comb begin
         mode_d   = mode_q;
         period_d = period_q;
         on_d     = on_q;
         phase_d  = phase_q;
         if (wrHit) begin
            mode_d   = mode_e'(cfg.wr_mode);
            period_d = cfg.wr_period;
            on_d     = cfg.wr_on;
            phase_d  = '0;
         end else begin
            unique case (mode_q)
               MODE_BLINK: begin
                  if (tick) begin
                     phase_d = (phase_q == effPeriod - 1'b1) ? '0 : phaseInc;
                  end
               end
               MODE_ONESHOT: begin
                  if (on_q == '0) begin
                     mode_d  = MODE_OFF;
                     phase_d = '0;
                  end else if (tick) begin
                     if (phaseInc == on_q) begin
                        mode_d  = MODE_OFF;
                        phase_d = '0;
                     end else begin
                        phase_d = phaseInc;
                     end
                  end
               end
               default: begin
                  phase_d = '0;
               end
            endcase
         end
      end

      // Channel output function ahead of the shared output register
      always_comb begin
         chanOnK = 1'b0;
         unique case (mode_q)
            MODE_OFF:     chanOnK = 1'b0;
            MODE_ON:      chanOnK = 1'b1;
            MODE_BLINK,
            MODE_ONESHOT: chanOnK = (phase_q < on_q);
            default:      chanOnK = 1'b0;
         endcase
      end

      assign chanOn[k] = chanOnK;

      // Per-channel configuration and phase registers
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            mode_q   <= MODE_OFF;
            period_q <= '0;
            on_q     <= '0;
            phase_q  <= '0;
         end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            on_q     <= on_d;
            phase_q  <= phase_d;
         end
      end
   end

   // Output register; the enable masks the pins without touching timing,
   // so re-enabling resumes exactly where the channels would have been.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         led_q <= '0;
      end else begin
         led_q <= chanOn & {N_CH{i_enable}};
      end
   end

   assign o_led  = led_q;
   assign o_tick = tick;

endmodule

// File: tb/tb_led_blinker_multi.sv
// ---------------------------------------------------------------------------
// tb_led_blinker_multi
// Self-checking bench for led_blinker_multi (N_CH=3, tick every 10 clocks,
// CNT_W=8). A behavioural model tracks each channel as an integer phase
// (BLINK) or a remaining-tick count (ONESHOT) and the tick as a function of
// clocks since reset; o_led and o_tick are compared every cycle.
// ---------------------------------------------------------------------------
module tb_led_blinker_multi;

   localparam int N_CH  = 3;
   localparam int DIV   = 10;
   localparam int CNT_W = 8;

   localparam int M_OFF     = 0;
   localparam int M_ON      = 1;
   localparam int M_BLINK   = 2;
   localparam int M_ONESHOT = 3;

   logic            clk;
   logic            rst;
   logic            enable;
   logic [N_CH-1:0] led;
   logic            tickOut;

   led_blinker_multi_if #(.CH_W(2), .CNT_W(CNT_W)) bif ();

   led_blinker_multi #(
      .N_CH    (N_CH),
      .CLK_HZ  (DIV),
      .TICK_HZ (1),
      .CNT_W   (CNT_W)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_enable (enable),
      .cfg      (bif),
      .o_led    (led),
      .o_tick   (tickOut)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   int mMode   [N_CH];
   int mPeriod [N_CH];
   int mOn     [N_CH];
   int mPhase  [N_CH];
   int mRemain [N_CH];
   int edgeCount;
   logic            modelTick;
   logic [N_CH-1:0] modelLed;

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Everything returns to zero / OFF
   task automatic resetModel();
      for (int k = 0; k < N_CH; k++) begin
         mMode[k]   = M_OFF;
         mPeriod[k] = 0;
         mOn[k]     = 0;
         mPhase[k]  = 0;
         mRemain[k] = 0;
      end
      edgeCount = 0;
      modelTick = 1'b0;
      modelLed  = '0;
   endtask

   // What a channel shows right now, from its abstract state
   function automatic logic chanModel(input int k);
      case (mMode[k])
         M_ON:      return 1'b1;
         M_BLINK:   return mPhase[k] < mOn[k];
         M_ONESHOT: return mRemain[k] > 0;
         default:   return 1'b0;
      endcase
   endfunction

   // Advance the reference by one clock edge given the sampled inputs
   task automatic modelStep(input logic we, input int ch, input int md,
                            input int per, input int onT, input logic en);
      logic [N_CH-1:0] nextLed;
      logic            tickEvent;
      int              p;
      for (int k = 0; k < N_CH; k++) nextLed[k] = chanModel(k) & en;
      tickEvent = modelTick;
      for (int k = 0; k < N_CH; k++) begin
         if (we && ch == k) begin
            mMode[k]   = md;
            mPeriod[k] = per;
            mOn[k]     = onT;
            mPhase[k]  = 0;
            mRemain[k] = onT;
         end else if (mMode[k] == M_BLINK) begin
            p = (mPeriod[k] == 0) ? 1 : mPeriod[k];
            if (tickEvent) mPhase[k] = (mPhase[k] + 1) % p;
         end else if (mMode[k] == M_ONESHOT) begin
            if (mRemain[k] == 0) begin
               mMode[k] = M_OFF;
            end else if (tickEvent) begin
               mRemain[k]--;
               if (mRemain[k] == 0) mMode[k] = M_OFF;
            end
         end
      end
      edgeCount++;
      modelTick = (edgeCount % DIV == 0);
      modelLed  = nextLed;
   endtask

   // Drive one cycle of inputs, clock it, then compare just after the edge
   task automatic applyStimulus(input logic we, input int ch, input int md,
                                input int per, input int onT, input logic en);
      bif.wr_en     = we;
      bif.wr_ch     = 2'(ch);
      bif.wr_mode   = 2'(md);
      bif.wr_period = CNT_W'(per);
      bif.wr_on     = CNT_W'(onT);
      enable        = en;
      @(posedge clk);
      modelStep(we, ch, md, per, onT, en);
      #1;
      checkOutput("led", 32'(led), 32'(modelLed));
      checkOutput("tick", 32'(tickOut), 32'(modelTick));
   endtask

   task automatic idle(input int n, input logic en);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0, 0, en);
   endtask

   initial begin
      rst           = 1'b1;
      enable        = 1'b1;
      bif.wr_en     = 1'b0;
      bif.wr_ch     = '0;
      bif.wr_mode   = '0;
      bif.wr_period = '0;
      bif.wr_on     = '0;
      resetModel();
      #2;
      checkOutput("rstLed", 32'(led), 32'd0);
      checkOutput("rstTick", 32'(tickOut), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // First tick lands on the tenth edge after release
      idle(12, 1'b1);

      // ch1 BLINK period 4 on 1: one tick high, three low
      applyStimulus(1'b1, 1, M_BLINK, 4, 1, 1'b1);
      idle(80, 1'b1);

      // ch2 ONESHOT on 3, then further ticks must stay dark
      applyStimulus(1'b1, 2, M_ONESHOT, 0, 3, 1'b1);
      idle(60, 1'b1);

      // ONESHOT with on 0 never lights; with on > period it is not wrapped
      applyStimulus(1'b1, 2, M_ONESHOT, 5, 0, 1'b1);
      idle(5, 1'b1);
      applyStimulus(1'b1, 2, M_ONESHOT, 2, 4, 1'b1);
      idle(50, 1'b1);

      // Rewrite ch1 exactly on a tick cycle
      for (int g = 0; g < 2 * DIV && !modelTick; g++) idle(1, 1'b1);
      checkOutput("tickAlign", 32'(tickOut), 32'd1);
      applyStimulus(1'b1, 1, M_BLINK, 4, 1, 1'b1);
      idle(45, 1'b1);

      // Enable low for 25 clocks mid-blink, then resume in phase
      idle(25, 1'b0);
      idle(40, 1'b1);

      // Duty edges on ch0, then an out-of-range write
      applyStimulus(1'b1, 0, M_BLINK, 0, 0, 1'b1);
      idle(20, 1'b1);
      applyStimulus(1'b1, 0, M_BLINK, 5, 7, 1'b1);
      idle(60, 1'b1);
      applyStimulus(1'b1, 3, M_OFF, 0, 0, 1'b1);
      idle(20, 1'b1);

      // Asynchronous reset while ch0 is lit
      checkOutput("preRstLed0", 32'(led[0]), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("asyncRstLed", 32'(led), 32'd0);
      checkOutput("asyncRstTick", 32'(tickOut), 32'd0);
      resetModel();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(12, 1'b1);

      // Randomized writes and enable toggling against the reference
      for (int i = 0; i < 3000; i++) begin
         logic we;
         logic en;
         we = ($urandom_range(0, 7) == 0);
         en = (i % 200 < 170) ? 1'b1 : ($urandom_range(0, 3) != 0);
         applyStimulus(we, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 7), $urandom_range(0, 9), en);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
